// File: rtl/verdict_tally_if.sv
// Verdict handshake bundle between the voter stage (master) and the tally (slave).
interface verdict_tally_if;
  logic       v_valid;
  logic       v_ready;
  logic [3:1] verdict;

  modport master (
    output v_valid,
    output verdict,
    input  v_ready
  );

  modport slave (
    input  v_valid,
    input  verdict,
    output v_ready
  );
endinterface

// File: rtl/verdict_tally.sv
// verdict_tally: consumes one-hot voter verdicts (100 reject, 010 tie, 001 pass)
// over a valid/ready handshake, tallies ROUNDS legal verdicts per session and
// issues a one-hot session result with a one-cycle done pulse.
// Optional feature macro: TALLY_STRICT_EN -- an illegal code aborts the session
// straight into HOLD with result 000 and a done pulse.
// ROUNDS must lie in [1, 2^CW-1].
module verdict_tally #(
  parameter int unsigned ROUNDS = 8,
  parameter int unsigned CW     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  verdict_tally_if.slave vif,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  pass_cnt,
  output logic [CW-1:0]  tie_cnt,
  output logic [CW-1:0]  fail_cnt,
  output logic [CW-1:0]  err_cnt,
  output logic [3:1]     result
);

  localparam logic [3:1]    V_PASS     = 3'b001;
  localparam logic [3:1]    V_TIE      = 3'b010;
  localparam logic [3:1]    V_FAIL     = 3'b100;
  localparam logic [3:1]    V_NONE     = 3'b000;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  state_e        state_q;
  logic          v_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] pass_q;
  logic [CW-1:0] tie_q;
  logic [CW-1:0] fail_q;
  logic [CW-1:0] err_q;
  logic [CW-1:0] round_q;
  logic [3:1]    result_q;

  logic          hs_c;
  logic          is_pass_c;
  logic          is_tie_c;
  logic          is_fail_c;
  logic          legal_c;
  logic          last_c;

  logic [CW-1:0] pass_d;
  logic [CW-1:0] tie_d;
  logic [CW-1:0] fail_d;
  logic [CW-1:0] err_d;
  logic [CW-1:0] round_d;
  logic [3:1]    result_d;

  // Handshake detect and one-hot legality decode of the presented code
  always_comb begin
    hs_c      = vif.v_valid & v_ready_q;
    is_pass_c = (vif.verdict == V_PASS);
    is_tie_c  = (vif.verdict == V_TIE);
    is_fail_c = (vif.verdict == V_FAIL);
    legal_c   = is_pass_c | is_tie_c | is_fail_c;
    last_c    = legal_c & (round_q == LAST_ROUND);
  end

  // Counter next values for an accepted verdict; err_cnt saturates
  always_comb begin
    pass_d  = pass_q  + CW'(is_pass_c);
    tie_d   = tie_q   + CW'(is_tie_c);
    fail_d  = fail_q  + CW'(is_fail_c);
    round_d = round_q + CW'(legal_c);
    err_d   = (err_q == CNT_MAX) ? err_q : err_q + CW'(1);
  end

  // Session result: pass vs reject majority, tie count does not vote
  always_comb begin
    result_d = V_TIE;
    if (pass_q > fail_q) begin
      result_d = V_PASS;
    end else if (fail_q > pass_q) begin
      result_d = V_FAIL;
    end
  end

  // Session FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      v_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
      tie_q     <= '0;
      fail_q    <= '0;
      err_q     <= '0;
      round_q   <= '0;
      result_q  <= V_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            state_q   <= ST_COLLECT;
            v_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            pass_q    <= '0;
            tie_q     <= '0;
            fail_q    <= '0;
            err_q     <= '0;
            round_q   <= '0;
            result_q  <= V_NONE;
          end
        end
        ST_COLLECT: begin
          if (hs_c) begin
            if (legal_c) begin
              pass_q  <= pass_d;
              tie_q   <= tie_d;
              fail_q  <= fail_d;
              round_q <= round_d;
              if (last_c) begin
                state_q   <= ST_DECIDE;
                v_ready_q <= 1'b0;
              end
            end else begin
              err_q <= err_d;
`ifdef TALLY_STRICT_EN
              // Illegal code aborts: partial tallies stay visible, no result
              state_q   <= ST_HOLD;
              v_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              result_q  <= V_NONE;
`endif
            end
          end
        end
        ST_DECIDE: begin
          state_q  <= ST_HOLD;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= result_d;
        end
        default: begin
          state_q   <= ST_IDLE;
          v_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign vif.v_ready = v_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign tie_cnt     = tie_q;
  assign fail_cnt    = fail_q;
  assign err_cnt     = err_q;
  assign result      = result_q;

endmodule

// File: doc/verdict_tally.md
Name: verdict_tally

Overview:
- Sequential consumer of the 3-bit one-hot voter verdict code: 3'b100 = reject, 3'b010 = tie, 3'b001 = pass.
- Accepts one verdict per round over a valid/ready handshake and checks that each code is legal one-hot.
- Tallies pass, tie and reject counts over a session of ROUNDS legal verdicts, then issues a session result in the same one-hot encoding.
- Sits downstream of the combinational voter stage.

Parameters:
- ROUNDS, 8, number of legal verdicts per session; must be at least 1 and at most 2^CW-1.
- CW, 4, width of every counter output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new session; honoured only in IDLE or HOLD
- v_valid  input  1  verdict present on verdict
- v_ready  output  1  block can accept a verdict
- verdict  input  3  [3:1] one-hot verdict code
- busy  output  1  session in progress (COLLECT or DECIDE)
- done  output  1  one-cycle pulse; result is newly valid
- pass_cnt  output  CW  legal 3'b001 verdicts this session
- tie_cnt  output  CW  legal 3'b010 verdicts this session
- fail_cnt  output  CW  legal 3'b100 verdicts this session
- err_cnt  output  CW  illegal codes this session; saturates at all-ones
- result  output  3  [3:1] session result; 3'b000 while no result is held

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; v_ready=0, busy=0, done=0; all counters 0; result=3'b000; internal round counter 0.
- Reset mid-session: abandons the session immediately. No done pulse is issued.
- States: IDLE, COLLECT, DECIDE, HOLD.
- IDLE: v_ready=0.
  - start=1: clear all counters and the round counter; result=3'b000; go to COLLECT on the next cycle.
- COLLECT: v_ready=1, busy=1. A handshake is v_valid & v_ready at a rising edge.
  - Legal one-hot code: increment its counter and the round counter.
  - Illegal code (000, or two or more bits set): increment err_cnt (saturating). Round counter does not advance.
  - When an accepted legal verdict makes the round count equal ROUNDS: go to DECIDE. v_ready drops in the next cycle.
  - start is ignored in COLLECT.
- DECIDE: one cycle, v_ready=0, busy=1.
  - Result rule: pass_cnt > fail_cnt -> 3'b001; fail_cnt > pass_cnt -> 3'b100; equal -> 3'b010. tie_cnt does not vote.
  - result is registered at the end of DECIDE and the state moves to HOLD.
- HOLD: busy=0, v_ready=0.
  - done=1 in the first HOLD cycle only.
  - result and all counters are held stable. Verdicts are ignored.
  - start=1: same clearing as in IDLE; go to COLLECT. result returns to 000 in the next cycle.
- Latency: last legal handshake at edge k -> DECIDE during cycle k..k+1 -> result valid and done=1 in the cycle after edge k+1.
- Back-to-back handshakes are legal on every COLLECT cycle. No bubble is required.
- Legal counters never exceed ROUNDS, so they do not wrap.

Optional Feature:
- Macro: TALLY_STRICT_EN.
- Defined: an illegal code accepted in COLLECT
  - increments err_cnt;
  - moves to HOLD on the next edge, bypassing DECIDE;
  - forces result=3'b000 and pulses done in the first HOLD cycle.
  - The legal counters keep their partial values.
- Undefined: illegal codes are counted and skipped as described in Behaviour. The session always completes with ROUNDS legal verdicts.

Test Plan:
- Reset: assert rst_n=0 mid-COLLECT after 3 verdicts -> all counters 0, result=000, v_ready=0, busy=0 asynchronously; no done pulse.
- Pass majority (ROUNDS=8): start, then 5x 001, 2x 100, 1x 010 back-to-back -> pass_cnt=5, fail_cnt=2, tie_cnt=1, result=001; done high exactly one cycle, one cycle after DECIDE.
- Even split: 4x 100 then 4x 001 -> result=010. Then with 8x 010 -> result=010, tie_cnt=8.
- Illegal codes, macro undefined: interleave 000 and 011 among 8 legal 100 -> err_cnt=2, fail_cnt=8, result=100; session ends only after the 8th legal verdict.
- Handshake and start rules:
  - v_valid toggling at random cycles -> only handshake cycles counted.
  - start pulse in COLLECT ignored.
  - verdicts presented in HOLD ignored; counters unchanged.
  - start in HOLD clears the counters and reopens COLLECT.
- Strict mode, TALLY_STRICT_EN defined: 001, 001, then 110 -> err_cnt=1, pass_cnt=2, result=000, done pulse one cycle after the 110 handshake.
